fetch_packer: RTL and testbench
===============================

// Module: fetch_packer
// PURPOSE
//  Front-end writer for the instruction buffer. Fetches 8-word I-cache lines.
//  Left-aligns the words from the current PC to the end of the line.
//  Writes them to the buffer as a contiguous low-aligned lane mask, with per-lane PCs.
//  Sits between the I-cache and the instruction buffer; takes flush/redirect from the backend.
// PARAMETERS
//  DATA_WIDTH  32            instruction width
//  ADDR_WIDTH  32            PC width
//  DEPTH       32            buffer depth; must match the buffer's Depth
//  RESET_PC    32'h8000_0000 first fetch PC after reset
// PORTS
//  clk            in  1            clock
//  rst            in  1            synchronous reset, active-low (0 = reset)
//  redirect_valid in  1            backend flush + new PC
//  redirect_pc    in  ADDR_WIDTH   redirect target, word aligned
//  ic_req_valid   out 1            line request valid
//  ic_req_ready   in  1            I-cache accepts request
//  ic_req_addr    out ADDR_WIDTH   line address, {pc[31:5],5'b0}
//  ic_resp_valid  in  1            line data valid (no ready; always consumed)
//  ic_resp_data   in  8*DATA_WIDTH word i = bits [32i+31:32i]
//  buf_count      in  $clog2(DEPTH) buffer occupancy
//  buf_clr        out 1            buffer clear
//  inst_wen       out 8            lane write enables; always 0...01...1
//  inst_o[7:0]    out DATA_WIDTH   packed instructions; lane 0 = oldest
//  pc_o[7:0]      out ADDR_WIDTH   PC per lane
// BEHAVIOUR
//  - Reset: pc_q=RESET_PC, state=S_REQ. ic_req_valid=0, inst_wen=0, buf_clr=0, inst_o/pc_o=0.
//  - free = (DEPTH-1) - buf_count. A request is issued only when free >= 8, so the worst-case line always fits.
//  - S_REQ: ic_req_valid = (free>=8). On valid&ready -> S_WAIT. The addr is held stable while valid&!ready.
//  - S_WAIT: on ic_resp_valid, off = pc_q[4:2] and n = 8-off.
//    - Lanes 0..n-1 <= words off..7, with pc_o[i] = pc_q + 4i.
//    - wen_q <= (1<<n)-1 and pc_q <= {pc_q[31:5]+1,5'b0}.
//    - Then -> S_WR.
//  - S_WR: inst_wen = wen_q for exactly 1 cycle (1-cycle registered latency from the response), then -> S_SYNC.
//  - S_SYNC: 1 idle cycle so buf_count reflects the write, then -> S_REQ.
//  - Redirect has priority in every state:
//    - buf_clr = redirect_valid, combinationally, and inst_wen is forced to 0 in that cycle.
//    - pc_q <= redirect_pc.
//    - From S_WAIT, or on a handshake in S_REQ in the same cycle: -> S_DROP.
//    - A response arriving in the redirect cycle itself is discarded and the next state is S_REQ.
//    - From any other state: -> S_REQ.
//  - S_DROP: discard the next ic_resp_valid beat, then -> S_REQ. A redirect here updates pc_q and stays in S_DROP.
//  - At most one outstanding request. Responses outside S_WAIT/S_DROP are a protocol error (assertion).
//  - pc arithmetic wraps modulo 2^ADDR_WIDTH.
//  - Reset mid-transaction returns to S_REQ. The I-cache is reset by the same rst, so no stale beat follows.
// CONFIGURATION
//  FETCH_JAL_PREDECODE_EN defined:
//   - Scan packed lanes 0..n-1 for opcode 7'b1101111. At the first hit, lane k:
//     - wen_q <= (1<<(k+1))-1.
//     - pc_q <= pc_k + sext(J-imm).
//   - Backend redirects still override.
//  Undefined:
//   - Purely sequential fetch; no opcode inspection logic is generated.
// STRUCTURE
//  fetch_pkg:
//   - LINE_WORDS=8 and OPC_JAL.
//   - typedef enum {S_REQ,S_WAIT,S_WR,S_SYNC,S_DROP} fetch_state_e.
//   - function jal_imm(inst) -> sign-extended offset.
//  fetch_predecode (sub-module, instantiated only under the macro):
//   - Inputs: packed lanes, valid mask.
//   - Outputs: hit, first-hit index k, target PC.
//  Lane compaction (barrel shift by off) and the FSM are inline.
// TESTING
//  1. Reset, pc=0x8000_0000, ready=1, buf_count=0, response of words W0..W7
//     -> addr 0x8000_0000; wen=8'hFF one cycle later; pc_o[7]=0x8000_001C; next addr 0x8000_0020.
//  2. redirect_pc=0x8000_0014, then response -> wen=8'h07; inst_o[0]=W5, pc_o[0]=0x8000_0014; next addr 0x8000_0020.
//  3. buf_count=24 (free=7) -> ic_req_valid stays 0; buf_count=23 -> request issued the next cycle.
//  4. Redirect to 0x8000_1000 while in S_WAIT
//     -> buf_clr=1 for 1 cycle; the stale response gives wen=0; next addr 0x8000_1000.
//  5. Redirect in the same cycle as ic_resp_valid -> response discarded, no S_DROP, next addr = redirect line.
//  6. (macro) JAL with imm=+0x40 in lane 2 of line 0x8000_0000
//     -> wen=8'h07; next addr 0x8000_0040. Without macro -> wen=8'hFF.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch packer: line geometry, JAL opcode,
// FSM state encoding and the J-type immediate decoder.
package fetch_pkg;

   localparam int         LINE_WORDS = 8;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT,
      S_WR,
      S_SYNC,
      S_DROP
   } fetch_state_e;

   // Sign-extended J-type immediate: imm[20|10:1|11|19:12] sits in inst[31:12].
   function automatic logic [31:0] jal_imm(input logic [31:0] inst);
      return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_packer_if.sv
// Bus bundle between the fetch packer, the I-cache, the instruction buffer and
// the backend redirect source. The packer uses the master modport.
//
// Handshake rules: the line request transfers on a cycle where ic_req_valid and
// ic_req_ready are both high; while valid is high and ready is low the address
// stays stable. ic_resp_valid has no ready and is consumed in the cycle it is
// high. inst_wen is a one-cycle write strobe with no back-pressure.
interface fetch_packer_if
   import fetch_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 32
);
   localparam int CW = $clog2(DEPTH);

   logic                             redirect_valid;
   logic [ADDR_WIDTH-1:0]            redirect_pc;
   logic                             ic_req_valid;
   logic                             ic_req_ready;
   logic [ADDR_WIDTH-1:0]            ic_req_addr;
   logic                             ic_resp_valid;
   logic [LINE_WORDS*DATA_WIDTH-1:0] ic_resp_data;
   logic [CW-1:0]                    buf_count;
   logic                             buf_clr;
   logic [LINE_WORDS-1:0]            inst_wen;
   logic [DATA_WIDTH-1:0]            inst_o [LINE_WORDS];
   logic [ADDR_WIDTH-1:0]            pc_o   [LINE_WORDS];

   modport master (
      input  redirect_valid, redirect_pc, ic_req_ready, ic_resp_valid, ic_resp_data, buf_count,
      output ic_req_valid, ic_req_addr, buf_clr, inst_wen, inst_o, pc_o
   );

   modport slave (
      output redirect_valid, redirect_pc, ic_req_ready, ic_resp_valid, ic_resp_data, buf_count,
      input  ic_req_valid, ic_req_addr, buf_clr, inst_wen, inst_o, pc_o
   );

endinterface

// File: rtl/fetch_predecode.sv
// JAL predecoder for packed fetch lanes. Only compiled when
// FETCH_JAL_PREDECODE_EN is defined; the default build has no opcode logic.
`ifdef FETCH_JAL_PREDECODE_EN
module fetch_predecode
   import fetch_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] lanes_i [LINE_WORDS],
   input  logic [LINE_WORDS-1:0] valid_i,
   input  logic [ADDR_WIDTH-1:0] base_pc_i,
   output logic                  hit_o,
   output logic [2:0]            idx_o,
   output logic [ADDR_WIDTH-1:0] target_o
);

   // Scan from the top lane down so the lowest-indexed JAL wins.
   always_comb begin
      hit_o    = 1'b0;
      idx_o    = '0;
      target_o = '0;
      for (int i = LINE_WORDS - 1; i >= 0; i--) begin
         if (valid_i[i] && lanes_i[i][6:0] == OPC_JAL) begin
            hit_o    = 1'b1;
            idx_o    = 3'(i);
            target_o = base_pc_i + ADDR_WIDTH'(4 * i) + ADDR_WIDTH'(jal_imm(lanes_i[i][31:0]));
         end
      end
   end

endmodule
`endif

// File: rtl/fetch_packer.sv
// Fetch packer: requests 8-word I-cache lines, left-aligns the words from the
// current PC and writes them to the instruction buffer as a low-aligned lane
// mask with per-lane PCs. Backend redirects flush the buffer and retarget.
// Optional feature macro: FETCH_JAL_PREDECODE_EN (stop the group at the first
// JAL and continue fetching from its target).
module fetch_packer
   import fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DEPTH      = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
   input  logic           clk,
   input  logic           rst,
   fetch_packer_if.master bus,
   output fetch_state_e   state_o
);

   localparam int CW = $clog2(DEPTH);
   typedef logic [CW:0] cnt_t;

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [LINE_WORDS-1:0] wen_q, wen_d;
   logic [DATA_WIDTH-1:0] inst_q [LINE_WORDS];
   logic [ADDR_WIDTH-1:0] lpc_q  [LINE_WORDS];

   logic [DATA_WIDTH-1:0] lane_inst [LINE_WORDS];
   logic [ADDR_WIDTH-1:0] lane_pc   [LINE_WORDS];
   logic                  capture;
   cnt_t                  free;
   logic                  room;
   logic                  req_valid;
   logic                  req_fire;
   logic [2:0]            off;
   logic [LINE_WORDS-1:0] line_mask;
   logic [ADDR_WIDTH-1:0] seq_pc;
   logic [LINE_WORDS-1:0] fetch_mask;
   logic [ADDR_WIDTH-1:0] fetch_pc;

   // Only ask for a line when a full line is guaranteed to fit in the buffer.
   assign free      = cnt_t'(DEPTH - 1) - {1'b0, bus.buf_count};
   assign room      = free >= cnt_t'(LINE_WORDS);
   assign req_valid = rst && (state_q == S_REQ) && room;
   assign req_fire  = req_valid && bus.ic_req_ready;

   assign off       = pc_q[4:2];
   assign line_mask = 8'hFF >> off;
   assign seq_pc    = {pc_q[ADDR_WIDTH-1:5] + (ADDR_WIDTH-5)'(1), 5'b0};

   // Barrel shift: lane i takes word off+i; lanes past the end of the line are zero.
   always_comb begin
      for (int i = 0; i < LINE_WORDS; i++) begin
         lane_inst[i] = '0;
         lane_pc[i]   = '0;
         if (line_mask[i]) begin
            lane_inst[i] = bus.ic_resp_data[DATA_WIDTH * int'(3'(i + int'(off))) +: DATA_WIDTH];
            lane_pc[i]   = pc_q + ADDR_WIDTH'(4 * i);
         end
      end
   end

`ifdef FETCH_JAL_PREDECODE_EN
   logic                  pd_hit;
   logic [2:0]            pd_idx;
   logic [ADDR_WIDTH-1:0] pd_target;

   fetch_predecode #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_predecode (
      .lanes_i   (lane_inst),
      .valid_i   (line_mask),
      .base_pc_i (pc_q),
      .hit_o     (pd_hit),
      .idx_o     (pd_idx),
      .target_o  (pd_target)
   );

   // A JAL truncates the group after itself and supplies the next fetch PC.
   always_comb begin
      fetch_mask = line_mask;
      fetch_pc   = seq_pc;
      if (pd_hit) begin
         fetch_mask = 8'hFF >> (3'd7 - pd_idx);
         fetch_pc   = pd_target;
      end
   end
`else
   assign fetch_mask = line_mask;
   assign fetch_pc   = seq_pc;
`endif

   // Next-state logic; a backend redirect overrides everything else.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      wen_d   = wen_q;
      capture = 1'b0;
      case (state_q)
         S_REQ:   if (req_fire) state_d = S_WAIT;
         S_WAIT: begin
            if (bus.ic_resp_valid) begin
               capture = 1'b1;
               wen_d   = fetch_mask;
               pc_d    = fetch_pc;
               state_d = S_WR;
            end
         end
         S_WR:    state_d = S_SYNC;
         S_SYNC:  state_d = S_REQ;
         S_DROP:  if (bus.ic_resp_valid) state_d = S_REQ;
         default: state_d = S_REQ;
      endcase
      if (bus.redirect_valid) begin
         capture = 1'b0;
         wen_d   = wen_q;
         pc_d    = bus.redirect_pc;
         // A request still in flight must have its response swallowed, unless
         // that response is the one arriving right now.
         if ((state_q == S_WAIT || state_q == S_DROP) && !bus.ic_resp_valid)
            state_d = S_DROP;
         else if (state_q == S_REQ && req_fire)
            state_d = S_DROP;
         else
            state_d = S_REQ;
      end
   end

   // State, PC, write mask and packed lane registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         wen_q   <= '0;
         for (int i = 0; i < LINE_WORDS; i++) begin
            inst_q[i] <= '0;
            lpc_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wen_q   <= wen_d;
         if (capture) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
               inst_q[i] <= lane_inst[i];
               lpc_q[i]  <= lane_pc[i];
            end
         end
      end
   end

   assign bus.ic_req_valid = req_valid;
   assign bus.ic_req_addr  = {pc_q[ADDR_WIDTH-1:5], 5'b0};
   assign bus.buf_clr      = rst && bus.redirect_valid;
   assign bus.inst_wen     = (rst && state_q == S_WR && !bus.redirect_valid) ? wen_q : '0;
   assign bus.inst_o       = inst_q;
   assign bus.pc_o         = lpc_q;
   assign state_o          = state_q;

   resp_in_window: assert property (@(posedge clk) disable iff (!rst)
      bus.ic_resp_valid |-> (state_q == S_WAIT || state_q == S_DROP));

endmodule

// File: tb/tb_fetch_packer.sv
// Testbench for fetch_packer: directed scenarios followed by randomized
// fetch/redirect traffic, checked against a transaction-level model.
module tb_fetch_packer;
   import fetch_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   fetch_state_e dbg_state;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [31:0]  exp_q[$];
   logic [31:0]  exp_pc_q[$];
   logic [31:0]  m_pc;

   fetch_packer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32)) bus ();

   fetch_packer #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .DEPTH      (32),
      .RESET_PC   (32'h8000_0000)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.master),
      .state_o (dbg_state)
   );

   // clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] jal_enc(input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
   endfunction

   function automatic logic [31:0] jal_off(input logic [31:0] w);
      logic [20:0] imm;
      imm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
      return {{11{imm[20]}}, imm};
   endfunction

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic [31:0] rand_pc();
      if ($urandom_range(0, 3) == 0) return 32'hFFFF_FF00 + 32'(4 * $urandom_range(0, 63));
      return 32'h8000_0000 + 32'(4 * $urandom_range(0, 1023));
   endfunction

   // Reference: from the model PC, which words land in which lanes, and where fetch goes next.
   task automatic model_fetch(input logic [255:0] l, output logic [7:0] mask);
      int          off, n;
      logic        found;
      logic [31:0] nxt, w;
      off   = int'(m_pc[4:2]);
      n     = 8 - off;
      nxt   = {m_pc[31:5], 5'b0} + 32'd32;
      found = 1'b0;
`ifdef FETCH_JAL_PREDECODE_EN
      for (int k = 0; k < 8 - off; k++) begin
         w = l[32*(off+k) +: 32];
         if (!found && w[6:0] == 7'h6F) begin
            found = 1'b1;
            n     = k + 1;
            nxt   = m_pc + 32'(4 * k) + jal_off(w);
         end
      end
`endif
      for (int k = 0; k < n; k++) begin
         w = l[32*(off+k) +: 32];
         exp_q.push_back(w);
         exp_pc_q.push_back(m_pc + 32'(4 * k));
      end
      mask = 8'((1 << n) - 1);
      m_pc = nxt;
   endtask

   // driver tasks: each starts and ends 1 time unit after a falling edge
   task automatic wait_req(input string tag);
      int cyc = 0;
      while (!bus.ic_req_valid && cyc < 20) begin
         @(negedge clk); #1;
         cyc++;
      end
      check({tag, "_req_valid"}, 64'(bus.ic_req_valid), 64'(1));
      check({tag, "_req_addr"}, 64'(bus.ic_req_addr), 64'({m_pc[31:5], 5'b0}));
   endtask

   task automatic handshake(input int stall);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk); #1;
         check("stall_addr_hold", 64'(bus.ic_req_addr), 64'({m_pc[31:5], 5'b0}));
      end
      bus.ic_req_ready = 1'b1;
      @(negedge clk);
      bus.ic_req_ready = 1'b0;
      #1;
      check("wait_no_req", 64'(bus.ic_req_valid), 64'(0));
   endtask

   task automatic redirect(input logic [31:0] pc);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = pc;
      #1;
      check("redir_buf_clr", 64'(bus.buf_clr), 64'(1));
      check("redir_wen_off", 64'(bus.inst_wen), 64'(0));
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      #1;
      check("redir_clr_pulse", 64'(bus.buf_clr), 64'(0));
      m_pc = pc;
   endtask

   task automatic resp_and_check(input logic [255:0] l, input int delay, input bit kill);
      logic [7:0] mask;
      int         n;
      for (int d = 0; d < delay; d++) begin
         @(negedge clk); #1;
         check("wait_wen_idle", 64'(bus.inst_wen), 64'(0));
      end
      model_fetch(l, mask);
      bus.ic_resp_valid = 1'b1;
      bus.ic_resp_data  = l;
      #1;
      check("resp_cycle_wen", 64'(bus.inst_wen), 64'(0));
      @(negedge clk);
      bus.ic_resp_valid = 1'b0;
      #1;
      if (kill) begin
         redirect(rand_pc());
         exp_q.delete();
         exp_pc_q.delete();
      end else begin
         check("wr_wen", 64'(bus.inst_wen), 64'(mask));
         n = $countones(mask);
         for (int i = 0; i < n; i++) begin
            check("lane_inst", 64'(bus.inst_o[i]), 64'(exp_q.pop_front()));
            check("lane_pc", 64'(bus.pc_o[i]), 64'(exp_pc_q.pop_front()));
         end
         @(negedge clk); #1;
         check("sync_wen_zero", 64'(bus.inst_wen), 64'(0));
      end
   endtask

   task automatic drop_case(input logic [31:0] pc, input bit same_cycle);
      if (same_cycle) begin
         bus.ic_resp_valid  = 1'b1;
         bus.ic_resp_data   = rand_line();
         bus.redirect_valid = 1'b1;
         bus.redirect_pc    = pc;
         #1;
         check("samecyc_buf_clr", 64'(bus.buf_clr), 64'(1));
         @(negedge clk);
         bus.ic_resp_valid  = 1'b0;
         bus.redirect_valid = 1'b0;
         #1;
         m_pc = pc;
         check("samecyc_wen", 64'(bus.inst_wen), 64'(0));
         check("samecyc_no_drop", 64'(bus.ic_req_valid), 64'(1));
      end else begin
         redirect(pc);
         check("drop_no_req", 64'(bus.ic_req_valid), 64'(0));
         for (int d = 0; d < int'($urandom_range(0, 2)); d++) begin
            @(negedge clk); #1;
            check("drop_wait_wen", 64'(bus.inst_wen), 64'(0));
         end
         bus.ic_resp_valid = 1'b1;
         bus.ic_resp_data  = rand_line();
         @(negedge clk);
         bus.ic_resp_valid = 1'b0;
         #1;
         check("stale_wen", 64'(bus.inst_wen), 64'(0));
      end
   endtask

   // stimulus
   initial begin
      logic [255:0] l;
      int           mode;
      rst                = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h1234_5678;
      bus.ic_req_ready   = 1'b0;
      bus.ic_resp_valid  = 1'b0;
      bus.ic_resp_data   = '0;
      bus.buf_count      = '0;
      m_pc               = 32'h8000_0000;

      // reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_req_valid", 64'(bus.ic_req_valid), 64'(0));
      check("rst_wen", 64'(bus.inst_wen), 64'(0));
      check("rst_buf_clr", 64'(bus.buf_clr), 64'(0));
      check("rst_inst0", 64'(bus.inst_o[0]), 64'(0));
      check("rst_pc7", 64'(bus.pc_o[7]), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(S_REQ));
      bus.redirect_valid = 1'b0;
      rst                = 1'b1;
      #1;

      // 1: aligned line, all 8 lanes
      for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'hA0A0_0000 + 32'(i);
      wait_req("t1");
      handshake(0);
      resp_and_check(l, 0, 1'b0);
      wait_req("t1_next");

      // 2: redirect mid-line, only words 5..7 written
      redirect(32'h8000_0014);
      wait_req("t2");
      handshake(1);
      resp_and_check(l, 2, 1'b0);

      // 3: buffer occupancy threshold
      bus.buf_count = 5'd24;
      #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         check("full_no_req", 64'(bus.ic_req_valid), 64'(0));
      end
      bus.buf_count = 5'd23;
      @(negedge clk); #1;
      check("room_req", 64'(bus.ic_req_valid), 64'(1));
      wait_req("t3");
      handshake(0);
      resp_and_check(rand_line(), 1, 1'b0);

      // 4: redirect while waiting, stale beat discarded
      wait_req("t4");
      handshake(0);
      drop_case(32'h8000_1000, 1'b0);
      wait_req("t4_next");
      handshake(0);
      resp_and_check(rand_line(), 0, 1'b0);

      // 5: redirect coincides with the response
      wait_req("t5");
      handshake(0);
      drop_case(32'h8000_2008, 1'b1);
      wait_req("t5_next");
      handshake(0);
      resp_and_check(rand_line(), 0, 1'b0);

      // 6: JAL +0x40 in lane 2
      redirect(32'h8000_0000);
      wait_req("t6");
      handshake(0);
      l = rand_line();
      for (int i = 0; i < 8; i++) if (l[32*i +: 7] == 7'h6F) l[32*i] = 1'b0;
      l[64 +: 32] = jal_enc(21'h40);
      resp_and_check(l, 0, 1'b0);
      wait_req("t6_next");
      handshake(0);
      resp_and_check(rand_line(), 0, 1'b0);

      // PC wrap at the top of the address space
      redirect(32'hFFFF_FFF8);
      wait_req("wrap");
      handshake(0);
      resp_and_check(rand_line(), 0, 1'b0);
      wait_req("wrap_next");

      // redirect during the write cycle suppresses the write
      handshake(0);
      resp_and_check(rand_line(), 0, 1'b1);

      // randomized traffic
      for (int t = 0; t < 40; t++) begin
         bus.buf_count = 5'($urandom_range(0, 23));
         #1;
         if ($urandom_range(0, 3) == 0) redirect(rand_pc());
         wait_req("rnd");
         handshake(int'($urandom_range(0, 2)));
         mode = int'($urandom_range(0, 7));
         if (mode == 0) drop_case(rand_pc(), 1'b0);
         else if (mode == 1) drop_case(rand_pc(), 1'b1);
         else begin
            l = rand_line();
            if ($urandom_range(0, 2) == 0)
               l[32*$urandom_range(0, 7) +: 32] = jal_enc(21'(4 * $urandom_range(0, 255)) - 21'd512);
            resp_and_check(l, int'($urandom_range(0, 3)), mode == 2);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
